alu_checker: RTL and testbench

//   Synthesizable response checker for the 8-bit ALU, forming the receive end of its stimulus interface.

---
 rtl/alu_checker_if.sv | 30 +++
 rtl/alu_checker.sv | 209 ++++++++++++++++++++
 tb/tb_alu_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_checker_if.sv
// Stimulus bus shared by the 8-bit ALU and its response checker.
// The driver (bench or BIST sequencer) uses master; the checker uses slave.
interface alu_checker_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    // in_valid qualifies a/b/opcode/y for exactly the cycle it is high.
    // The checker never stalls, so there is no ready and every valid cycle is one transaction.
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid,
        output a,
        output b,
        output opcode,
        output y
    );

    modport slave (
        input in_valid,
        input a,
        input b,
        input opcode,
        input y
    );
endinterface

// File: rtl/alu_checker.sv
// Two-stage response checker for the 8-bit ALU: recomputes the result, flags mismatches,
// keeps saturating pass/err/illegal counters and holds the first failing transaction.
module alu_checker #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    alu_checker_if.slave     stim,
    output logic             chk_valid,
    output logic             mismatch,
    output logic             illegal,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt,
    output logic [1:0]       status,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y,
    output logic [WIDTH-1:0] fail_exp,
    output logic [OPW-1:0]   fail_op
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PASS  = 2'd1,
        ST_FAIL  = 2'd2
    } status_e;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [WIDTH-1:0] s1_exp_q, s1_exp_d;
    logic             s1_ill_q, s1_ill_d;

    // Stage 2 registers
    logic             chk_valid_q, chk_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    status_e          status_q, status_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic [WIDTH-1:0] fail_y_q, fail_y_d;
    logic [WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [OPW-1:0]   fail_op_q, fail_op_d;

    logic             pass_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Stage 1: capture the transaction and the reference result
    always_comb begin
        s1_valid_d = stim.in_valid & ~clear;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_y_d     = s1_y_q;
        s1_exp_d   = s1_exp_q;
        s1_ill_d   = s1_ill_q;
        if (stim.in_valid) begin
            s1_a_d   = stim.a;
            s1_b_d   = stim.b;
            s1_op_d  = stim.opcode;
            s1_y_d   = stim.y;
            s1_ill_d = 1'b0;
            case (stim.opcode)
                OPW'(0): s1_exp_d = stim.a + stim.b;
                OPW'(1): s1_exp_d = stim.a - stim.b;
                OPW'(2): s1_exp_d = stim.a & stim.b;
                OPW'(3): s1_exp_d = stim.a | stim.b;
                OPW'(4): s1_exp_d = ~stim.a;
                default: begin
                    s1_exp_d = '0;
                    s1_ill_d = 1'b1;
                end
            endcase
        end
    end

    // Stage 2: compare result; a clear in this cycle drops the stage-1 transaction
    always_comb begin
        chk_valid_d = s1_valid_q & ~clear;
        illegal_d   = chk_valid_d & s1_ill_q;
        mismatch_d  = chk_valid_d & ~s1_ill_q & (s1_y_q != s1_exp_q);
        pass_evt    = chk_valid_d & ~s1_ill_q & (s1_y_q == s1_exp_q);
    end

    // Counters and first-failure capture
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        ill_cnt_d  = ill_cnt_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_y_d   = fail_y_q;
        fail_exp_d = fail_exp_q;
        fail_op_d  = fail_op_q;
        if (clear) begin
            pass_cnt_d = '0;
            err_cnt_d  = '0;
            ill_cnt_d  = '0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_y_d   = '0;
            fail_exp_d = '0;
            fail_op_d  = '0;
        end else begin
            if (pass_evt)   pass_cnt_d = sat_inc(pass_cnt_q);
            if (mismatch_d) err_cnt_d  = sat_inc(err_cnt_q);
            if (illegal_d)  ill_cnt_d  = sat_inc(ill_cnt_q);
            // Only the mismatch that enters FAIL is captured
            if (mismatch_d && status_q != ST_FAIL) begin
                fail_a_d   = s1_a_q;
                fail_b_d   = s1_b_q;
                fail_y_d   = s1_y_q;
                fail_exp_d = s1_exp_q;
                fail_op_d  = s1_op_q;
            end
        end
    end

    // Status FSM next state
    always_comb begin
        status_d = status_q;
        if (clear) begin
            status_d = ST_EMPTY;
        end else begin
            case (status_q)
                ST_EMPTY: begin
                    if (mismatch_d)    status_d = ST_FAIL;
                    else if (pass_evt) status_d = ST_PASS;
                end
                ST_PASS: begin
                    if (mismatch_d) status_d = ST_FAIL;
                end
                ST_FAIL:  status_d = ST_FAIL;
                default:  status_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_y_q      <= '0;
            s1_exp_q    <= '0;
            s1_ill_q    <= 1'b0;
            chk_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            illegal_q   <= 1'b0;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            ill_cnt_q   <= '0;
            status_q    <= ST_EMPTY;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_y_q    <= '0;
            fail_exp_q  <= '0;
            fail_op_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_y_q      <= s1_y_d;
            s1_exp_q    <= s1_exp_d;
            s1_ill_q    <= s1_ill_d;
            chk_valid_q <= chk_valid_d;
            mismatch_q  <= mismatch_d;
            illegal_q   <= illegal_d;
            pass_cnt_q  <= pass_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
            status_q    <= status_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_y_q    <= fail_y_d;
            fail_exp_q  <= fail_exp_d;
            fail_op_q   <= fail_op_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign mismatch  = mismatch_q;
    assign illegal   = illegal_q;
    assign pass_cnt  = pass_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign ill_cnt   = ill_cnt_q;
    assign status    = status_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_y    = fail_y_q;
    assign fail_exp  = fail_exp_q;
    assign fail_op   = fail_op_q;

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: hand-computed vectors, clear/reset behaviour,
// back-to-back streaming and counter saturation on a 4-bit-counter instance.
module tb_alu_checker;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    alu_checker_if #(.WIDTH(8), .OPW(3)) stim_if ();

    logic        chk_valid, mismatch, illegal;
    logic [15:0] pass_cnt, err_cnt, ill_cnt;
    logic [1:0]  status;
    logic [7:0]  fail_a, fail_b, fail_y, fail_exp;
    logic [2:0]  fail_op;

    logic        chk_valid4, mismatch4, illegal4;
    logic [3:0]  pass_cnt4, err_cnt4, ill_cnt4;
    logic [1:0]  status4;
    logic [7:0]  fail_a4, fail_b4, fail_y4, fail_exp4;
    logic [2:0]  fail_op4;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    alu_checker #(.WIDTH(8), .OPW(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .stim(stim_if),
        .chk_valid(chk_valid), .mismatch(mismatch), .illegal(illegal),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .ill_cnt(ill_cnt), .status(status),
        .fail_a(fail_a), .fail_b(fail_b), .fail_y(fail_y), .fail_exp(fail_exp),
        .fail_op(fail_op)
    );

    alu_checker #(.WIDTH(8), .OPW(3), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .stim(stim_if),
        .chk_valid(chk_valid4), .mismatch(mismatch4), .illegal(illegal4),
        .pass_cnt(pass_cnt4), .err_cnt(err_cnt4), .ill_cnt(ill_cnt4), .status(status4),
        .fail_a(fail_a4), .fail_b(fail_b4), .fail_y(fail_y4), .fail_exp(fail_exp4),
        .fail_op(fail_op4)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] y);
        stim_if.in_valid = 1'b1;
        stim_if.a        = a;
        stim_if.b        = b;
        stim_if.opcode   = op;
        stim_if.y        = y;
    endtask

    task automatic idle();
        stim_if.in_valid = 1'b0;
    endtask

    // Send one transaction and check its result two edges later
    task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] y,
                        input logic exp_mis, input logic exp_ill);
        drive(a, b, op, y);
        step();
        idle();
        check({tag, "_early"}, chk_valid, 1'b0);
        step();
        check({tag, "_vld"}, chk_valid, 1'b1);
        check({tag, "_mis"}, mismatch, exp_mis);
        check({tag, "_ill"}, illegal, exp_ill);
        step();
        check({tag, "_pulse"}, chk_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        stim_if.in_valid = 1'b0;
        stim_if.a = '0; stim_if.b = '0; stim_if.opcode = '0; stim_if.y = '0;

        // 1. reset
        step(); step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (chk_valid) pulses++;
        end
        check("rst_pulses", pulses, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ill", ill_cnt, 0);
        check("rst_status", status, 0);
        check("rst_fail_y", fail_y, 0);
        check("rst_fail_exp", fail_exp, 0);

        // 2. simple add
        send("add", 8'h0F, 8'h01, 3'd0, 8'h10, 1'b0, 1'b0);
        check("add_pass_cnt", pass_cnt, 1);
        check("add_status", status, 1);

        // 3. wrap cases after a clear
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_pass_cnt", pass_cnt, 0);
        check("clr_status", status, 0);
        send("sub_wrap", 8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 1'b0);
        send("add_wrap", 8'hFF, 8'h02, 3'd0, 8'h01, 1'b0, 1'b0);
        check("wrap_pass_cnt", pass_cnt, 2);
        check("wrap_status", status, 1);

        // 4. first failure and its capture
        send("and_bad", 8'hF0, 8'h3C, 3'd2, 8'h31, 1'b1, 1'b0);
        check("f1_err_cnt", err_cnt, 1);
        check("f1_status", status, 2);
        check("f1_fail_exp", fail_exp, 8'h30);
        check("f1_fail_y", fail_y, 8'h31);
        check("f1_fail_a", fail_a, 8'hF0);
        check("f1_fail_b", fail_b, 8'h3C);
        check("f1_fail_op", fail_op, 3'd2);
        send("or_bad", 8'h01, 8'h02, 3'd3, 8'h00, 1'b1, 1'b0);
        check("f2_err_cnt", err_cnt, 2);
        check("f2_fail_y", fail_y, 8'h31);
        check("f2_fail_exp", fail_exp, 8'h30);
        check("f2_fail_op", fail_op, 3'd2);
        send("not_ok", 8'h5A, 8'h00, 3'd4, 8'hA5, 1'b0, 1'b0);
        check("f3_status", status, 2);
        check("f3_pass_cnt", pass_cnt, 3);

        // 5. illegal opcodes
        send("op5", 8'h12, 8'h34, 3'd5, 8'h00, 1'b0, 1'b1);
        send("op7", 8'hAB, 8'hCD, 3'd7, 8'hEE, 1'b0, 1'b1);
        check("ill_cnt", ill_cnt, 2);
        check("ill_err_cnt", err_cnt, 2);
        check("ill_status", status, 2);
        check("ill_fail_y", fail_y, 8'h31);

        // 6. stream of four with clear during the third
        drive(8'h01, 8'h01, 3'd0, 8'h02);
        step();
        drive(8'h02, 8'h01, 3'd0, 8'h03);
        step();
        check("s_tx1_vld", chk_valid, 1'b1);
        check("s_tx1_pass_cnt", pass_cnt, 4);
        drive(8'h03, 8'h01, 3'd0, 8'h04);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("s_clr_vld", chk_valid, 1'b0);
        check("s_clr_pass_cnt", pass_cnt, 0);
        check("s_clr_err_cnt", err_cnt, 0);
        check("s_clr_ill_cnt", ill_cnt, 0);
        check("s_clr_status", status, 0);
        check("s_clr_fail_y", fail_y, 0);
        check("s_clr_fail_exp", fail_exp, 0);
        drive(8'h04, 8'h01, 3'd0, 8'h05);
        step();
        idle();
        check("s_drop_vld", chk_valid, 1'b0);
        step();
        check("s_tx4_vld", chk_valid, 1'b1);
        check("s_tx4_pass_cnt", pass_cnt, 1);
        check("s_tx4_status", status, 1);
        step();
        check("s_end_vld", chk_valid, 1'b0);

        // Mid-stream reset drops the in-flight transaction
        drive(8'h10, 8'h20, 3'd0, 8'h30);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_vld", chk_valid, 1'b0);
        check("mrst_pass_cnt", pass_cnt, 0);
        check("mrst_status", status, 0);
        step();
        check("mrst_vld2", chk_valid, 1'b0);

        // 20 back-to-back passes: no loss, 4-bit counters saturate
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(8'(i), 8'h03, 3'd0, 8'(i + 3));
            step();
            if (chk_valid) pulses++;
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            if (chk_valid) pulses++;
        end
        check("b2b_pulses", pulses, 20);
        check("b2b_pass_cnt16", pass_cnt, 20);
        check("b2b_pass_cnt4", pass_cnt4, 15);
        check("b2b_status4", status4, 1);
        check("b2b_err_cnt4", err_cnt4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
